// File: rtl/seg_display_ctrl_if.sv
// seg_display_ctrl_if: value handshake and status bundle between the
// register/MMIO write side (master) and the display sequencer (slave).
interface seg_display_ctrl_if;
  logic        in_valid;
  logic [15:0] in_value;
  logic        in_ready;
  logic        busy;
  logic        done;

  // Producer side: offers a value and watches sequencer status.
  modport master (
    output in_valid,
    output in_value,
    input  in_ready,
    input  busy,
    input  done
  );

  // Sequencer side: accepts a value and reports status.
  modport slave (
    input  in_valid,
    input  in_value,
    output in_ready,
    output busy,
    output done
  );
endinterface

// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: 5-digit decimal 7-segment display sequencer.
// Takes a 16-bit value over a valid/ready handshake and converts it to BCD
// with a bit-serial shift-add-3 FSM (16 shift cycles plus one commit cycle).
// It then time-multiplexes the committed digits onto one shared segment
// decoder with a one-hot digit enable.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero blanking).
module seg_display_ctrl #(
  parameter int         REFRESH_DIV   = 50000,
  parameter logic [6:0] BLANK_PATTERN = 7'h7F
) (
  input  logic                clk,
  input  logic                rst_n,
  seg_display_ctrl_if.slave   bus,
  output logic [4:0]          digit_en,
  output logic [6:0]          seg_out
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_UPDATE  = 2'd2;

  localparam int            CW           = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] REFRESH_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [4:0]    LAST_BIT     = 5'd15;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [19:0] add3_all(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int k = 0; k < 5; k++) begin
      if (b[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = b[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = b[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Shared binary_to_7Seg decode, active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] binary_to_7seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [15:0]   shift_reg;
  logic [19:0]   bcd_acc;
  logic [19:0]   bcd_adj;
  logic [4:0]    bit_cnt;
  logic [19:0]   disp_digits;
  logic          transfer;
  logic          in_ready_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] refresh_cnt;
  logic [2:0]    scan_idx;
  logic [3:0]    sel_digit;
  logic          sel_blank;

  assign transfer     = bus.in_valid & in_ready_q;
  assign bcd_adj      = add3_all(bcd_acc);
  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

  // Next-state decode for the conversion sequencer.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (transfer) begin
          state_next = ST_CONVERT;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_CONVERT: begin
        if (bit_cnt == LAST_BIT) begin
          state_next = ST_UPDATE;
        end else begin
          state_next = ST_CONVERT;
        end
      end
      ST_UPDATE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register plus registered ready/busy/done status derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      in_ready_q <= (state_next == ST_IDLE);
      busy_q     <= (state_next == ST_CONVERT) || (state_next == ST_UPDATE);
      if (state == ST_UPDATE) begin
        done_q <= 1'b1;
      end else begin
        done_q <= 1'b0;
      end
    end
  end

  // Shift-add-3 datapath: load on transfer, one input bit per CONVERT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= 16'd0;
      bcd_acc   <= 20'd0;
      bit_cnt   <= 5'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            shift_reg <= bus.in_value;
            bcd_acc   <= 20'd0;
            bit_cnt   <= 5'd0;
          end else begin
            shift_reg <= shift_reg;
          end
        end
        ST_CONVERT: begin
          {bcd_acc, shift_reg} <= {bcd_adj[18:0], shift_reg, 1'b0};
          bit_cnt              <= bit_cnt + 5'd1;
        end
        default: begin
          bit_cnt <= bit_cnt;
        end
      endcase
    end
  end

  // Display digit registers: only touched in UPDATE, so the old value shows during conversion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_digits <= 20'd0;
    end else if (state == ST_UPDATE) begin
      disp_digits <= bcd_acc;
    end else begin
      disp_digits <= disp_digits;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [4:0] blank_mask;
  logic [4:0] blank_next;

  // Blank digit k (k >= 1) when it and every higher digit are zero; the ones digit always shows.
  always_comb begin
    blank_next    = 5'b00000;
    blank_next[4] = (bcd_acc[19:16] == 4'd0);
    for (int k = 3; k >= 1; k--) begin
      blank_next[k] = blank_next[k+1] & (bcd_acc[4*k +: 4] == 4'd0);
    end
    blank_next[0] = 1'b0;
  end

  // Blank mask is latched together with the digits so both change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_mask <= 5'b00000;
    end else if (state == ST_UPDATE) begin
      blank_mask <= blank_next;
    end else begin
      blank_mask <= blank_mask;
    end
  end

  // Blank flag of the digit currently being scanned.
  always_comb begin
    sel_blank = 1'b0;
    case (scan_idx)
      3'd0:    sel_blank = blank_mask[0];
      3'd1:    sel_blank = blank_mask[1];
      3'd2:    sel_blank = blank_mask[2];
      3'd3:    sel_blank = blank_mask[3];
      3'd4:    sel_blank = blank_mask[4];
      default: sel_blank = 1'b0;
    endcase
  end
`else
  // Without blanking every digit is shown, leading zeros included.
  always_comb begin
    sel_blank = 1'b0;
  end
`endif

  // Refresh timer and scan index; free-running and independent of the conversion FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      scan_idx    <= 3'd0;
      digit_en    <= 5'b00001;
    end else if (refresh_cnt == REFRESH_LAST) begin
      refresh_cnt <= '0;
      if (scan_idx >= 3'd4) begin
        scan_idx <= 3'd0;
        digit_en <= 5'b00001;
      end else begin
        scan_idx <= scan_idx + 3'd1;
        digit_en <= {digit_en[3:0], 1'b0};
      end
    end else begin
      refresh_cnt <= refresh_cnt + CW'(1);
    end
  end

  // Pick the committed BCD digit selected by the scan index.
  always_comb begin
    sel_digit = 4'd0;
    case (scan_idx)
      3'd0:    sel_digit = disp_digits[3:0];
      3'd1:    sel_digit = disp_digits[7:4];
      3'd2:    sel_digit = disp_digits[11:8];
      3'd3:    sel_digit = disp_digits[15:12];
      3'd4:    sel_digit = disp_digits[19:16];
      default: sel_digit = 4'd0;
    endcase
  end

  // Segment output follows the scan index in the same cycle, no extra pipeline stage.
  always_comb begin
    if (sel_blank) begin
      seg_out = BLANK_PATTERN;
    end else begin
      seg_out = binary_to_7seg(sel_digit);
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: scoreboard bench for seg_display_ctrl (REFRESH_DIV = 4).
// Stimulus pushes {value, accept cycle} into a queue; a negedge monitor pops
// on done and checks latency, status, scan order and the segment code of the
// scanned digit against a decimal-arithmetic reference.
module tb_seg_display_ctrl;
  localparam int         DIV   = 4;
  localparam int         LAT   = 17;
  localparam logic [6:0] BLANK = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] digit_en;
  logic [6:0] seg_out;

  seg_display_ctrl_if bus();

  seg_display_ctrl #(.REFRESH_DIV(DIV), .BLANK_PATTERN(BLANK)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .digit_en (digit_en),
    .seg_out  (seg_out)
  );

  always #5 clk = ~clk;

  typedef struct { int value; int acc; } txn_t;
  txn_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ticks = 0;
  int   disp_val = 0;
  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ticks <= 0;
    else        ticks <= ticks + 1;
  end

  function automatic logic [6:0] exp_seg(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (LZB && k >= 1 && v < p) return BLANK;
    return seg_tab[(v / p) % 10];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        disp_val = 0;
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_digit_en", 32'(digit_en), 32'd1);
        check("rst_seg", 32'(seg_out), 32'h40);
      end else begin
        bit exp_done;
        bit exp_busy;
        int idx;
        exp_done = 1'b0;
        exp_busy = 1'b0;
        if (q.size() > 0 && cyc == q[0].acc + LAT) begin
          exp_done = 1'b1;
          disp_val = q[0].value;
          void'(q.pop_front());
        end else if (q.size() > 0 && cyc >= q[0].acc) begin
          exp_busy = 1'b1;
        end
        check("done", 32'(bus.done), 32'(exp_done));
        check("busy", 32'(bus.busy), 32'(exp_busy));
        check("in_ready", 32'(bus.in_ready), 32'(!exp_busy));
        idx = (ticks / DIV) % 5;
        check("digit_en", 32'(digit_en), 32'(1 << idx));
        check("seg_out", 32'(seg_out), 32'(exp_seg(disp_val, idx)));
      end
    end
  end

  // Offer a value and wait (bounded) until the DUT takes it; called at a negedge.
  task automatic send(input int v, input bit keep);
    bus.in_valid = 1'b1;
    bus.in_value = 16'(v);
    for (int i = 0; i < 200; i++) begin
      if (bus.in_ready) begin
        q.push_back('{v, cyc + 1});
        @(negedge clk);
        if (!keep) bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL send_timeout value=%0d: got in_ready=0 expected 1", v);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (q.size() == 0) return;
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL idle_timeout: got pending=%0d expected 0", q.size());
    q.delete();
  endtask

  initial begin
    int edge_vals[6] = '{9, 10, 99, 1000, 10000, 65534};
    bus.in_valid = 1'b0;
    bus.in_value = 16'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(12345, 1'b0); wait_idle(); repeat (22) @(negedge clk);
    send(65535, 1'b0); wait_idle(); repeat (22) @(negedge clk);
    send(0, 1'b0);     wait_idle(); repeat (22) @(negedge clk);
    send(100, 1'b1);   send(999, 1'b0); wait_idle(); repeat (22) @(negedge clk);
    send(42, 1'b0);    wait_idle(); repeat (22) @(negedge clk);

    // Reset in the eighth CONVERT cycle: abort, nothing committed.
    send(30000, 1'b0);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_ready", 32'(bus.in_ready), 32'd1);
    check("async_busy", 32'(bus.busy), 32'd0);
    check("async_digit_en", 32'(digit_en), 32'd1);
    check("async_seg", 32'(seg_out), 32'h40);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(negedge clk);

    foreach (edge_vals[i]) begin
      send(edge_vals[i], 1'b0);
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    for (int i = 0; i < 25; i++) begin
      send(int'($urandom_range(0, 65535)), 1'b0);
      repeat ($urandom_range(0, 25)) @(negedge clk);
    end
    wait_idle();
    repeat (22) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
